// File: rtl/fifo_rw_ctrl.sv
// Read/write pointer controller for the FIFO datapath.
// Keeps wrap-bit pointers, turns accepted producer/consumer requests into
// RAM strobes and addresses, and exports pointer status for the flag logic.
// Also holds sticky overflow/underflow flags and a synchronous flush.
module fifo_rw_ctrl #(
    parameter int a_length = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_req,
    input  logic                rd_req,
    input  logic                flush,
    input  logic                err_clr,
    output logic                wr_ready,
    output logic                rd_ready,
    output logic                mem_we,
    output logic [a_length-1:0] mem_waddr,
    output logic                mem_re,
    output logic [a_length-1:0] mem_raddr,
    output logic                rd_valid,
    output logic [a_length-1:0] ptr_diff,
    output logic                MSB_wr_ptr,
    output logic                MSB_rd_ptr,
    output logic [a_length:0]   count,
    output logic                ovf,
    output logic                udf
);

    logic [a_length:0] wr_ptr;
    logic [a_length:0] rd_ptr;
    logic              full;
    logic              empty;
    logic              wr_accept;
    logic              rd_accept;
    logic              ovf_set;
    logic              udf_set;

    // Decode full/empty from registered pointers and qualify the requests.
    always_comb begin
        full      = (wr_ptr[a_length] != rd_ptr[a_length]) &&
                    (wr_ptr[a_length-1:0] == rd_ptr[a_length-1:0]);
        empty     = (wr_ptr == rd_ptr);
        wr_accept = reset_n && wr_req && !full  && !flush;
        rd_accept = reset_n && rd_req && !empty && !flush;
        ovf_set   = reset_n && wr_req && full  && !flush;
        udf_set   = reset_n && rd_req && empty && !flush;
        wr_ready  = reset_n && !full;
        rd_ready  = reset_n && !empty;
        mem_we    = wr_accept;
        mem_re    = rd_accept;
        mem_waddr = wr_ptr[a_length-1:0];
        mem_raddr = rd_ptr[a_length-1:0];
        count     = wr_ptr - rd_ptr;
        ptr_diff  = count[a_length-1:0];
        MSB_wr_ptr = wr_ptr[a_length];
        MSB_rd_ptr = rd_ptr[a_length];
    end

    // Advance pointers on accepted transfers; flush snaps the read pointer
    // onto the write pointer so the FIFO reads as empty next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf_set || (ovf && !err_clr);
            udf <= udf_set || (udf && !err_clr);
        end
    end

    // RAM read data is valid one cycle after an accepted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
        end
    end

endmodule
